vector_lane_alu: RTL and testbench



---
 rtl/vector_lane_alu.sv | 199 +++++++++++++++++++
 tb/tb_vector_lane_alu.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_lane_alu.sv
`default_nettype none
// ============================================================================
//  Module   : vector_lane_alu
//  Purpose  : Multi-cycle vector execution stage. Captures the Va/Vb operand
//             pair on Vstart and computes LANES_PER_BEAT lanes per cycle
//             (VADD / VSUB / VMUL lane-wise, VDOT into a 2*LANE_W-bit
//             accumulator). It then issues one write-back strobe to the
//             vector register file.
//  Ports    : clk      - clock, all state on rising edge
//             Vreset   - asynchronous active-low reset
//             Vstart   - start pulse, accepted only when idle
//             Vop      - opcode (0 VADD, 1 VSUB, 2 VMUL, 3 VDOT)
//             Vdst     - destination vector register index
//             Va, Vb   - operand vectors, lane i = bits [16i+15:16i]
//             Vwrdata  - write-back vector (held until next write-back)
//             VwrAddr  - write-back register index (held)
//             VwrEn    - one-cycle write-back strobe
//             Vbusy    - high from accept until return to idle
//             Vdone    - one-cycle completion pulse
//  Revision : 1.0 - initial release
// ============================================================================
module vector_lane_alu #(
   parameter int LANE_W         = 16,
   parameter int NUM_LANES      = 16,
   parameter int LANES_PER_BEAT = 4
) (
   input  logic                          clk,
   input  logic                          Vreset,
   input  logic                          Vstart,
   input  logic [1:0]                    Vop,
   input  logic [2:0]                    Vdst,
   input  logic [LANE_W*NUM_LANES-1:0]   Va,
   input  logic [LANE_W*NUM_LANES-1:0]   Vb,
   output logic [LANE_W*NUM_LANES-1:0]   Vwrdata,
   output logic [2:0]                    VwrAddr,
   output logic                          VwrEn,
   output logic                          Vbusy,
   output logic                          Vdone
);

   localparam int VEC_W     = LANE_W * NUM_LANES;
   localparam int NUM_BEATS = NUM_LANES / LANES_PER_BEAT;
   localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam int PROD_W    = 2 * LANE_W;
   // Dot-product accumulator is as wide as one full product and wraps.
   localparam int ACC_W     = PROD_W;

   localparam logic [1:0] c_OP_ADD = 2'd0;
   localparam logic [1:0] c_OP_SUB = 2'd1;
   localparam logic [1:0] c_OP_MUL = 2'd2;
   localparam logic [1:0] c_OP_DOT = 2'd3;

   localparam logic [BEAT_W-1:0] c_LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_WB   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [BEAT_W-1:0]   r_beat;
   logic [VEC_W-1:0]    r_opa;
   logic [VEC_W-1:0]    r_opb;
   logic [1:0]          r_op;
   logic [2:0]          r_dst;
   logic [VEC_W-1:0]    r_result;
   logic [ACC_W-1:0]    r_acc;

   logic [VEC_W-1:0]    r_wrdata;
   logic [2:0]          r_wraddr;
   logic                r_wren;
   logic                r_busy;
   logic                r_done;

   logic [LANE_W-1:0]   w_a    [LANES_PER_BEAT];
   logic [LANE_W-1:0]   w_b    [LANES_PER_BEAT];
   logic [PROD_W-1:0]   w_prod [LANES_PER_BEAT];
   logic [LANE_W-1:0]   w_lane [LANES_PER_BEAT];
   logic [ACC_W-1:0]    w_dot_sum;

   // ------------------------------------------------------------------------
   // Lane datapath for the current beat: lanes beat*LPB .. beat*LPB+LPB-1.
   // ------------------------------------------------------------------------
   always_comb begin
      w_dot_sum = r_acc;
      for (int j = 0; j < LANES_PER_BEAT; j++) begin
         w_a[j]    = r_opa[(int'(r_beat) * LANES_PER_BEAT + j) * LANE_W +: LANE_W];
         w_b[j]    = r_opb[(int'(r_beat) * LANES_PER_BEAT + j) * LANE_W +: LANE_W];
         w_prod[j] = PROD_W'(w_a[j]) * PROD_W'(w_b[j]);
         w_lane[j] = '0;
         case (r_op)
            c_OP_ADD: w_lane[j] = w_a[j] + w_b[j];
            c_OP_SUB: w_lane[j] = w_a[j] - w_b[j];
            c_OP_MUL: w_lane[j] = w_prod[j][LANE_W-1:0];
            default:  w_lane[j] = '0;
         endcase
         w_dot_sum = w_dot_sum + w_prod[j];
      end
   end

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge Vreset) begin
      if (!Vreset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (Vstart) w_state_nxt = ST_EXEC;
         ST_EXEC: if (r_beat == c_LAST_BEAT) w_state_nxt = ST_WB;
         ST_WB:   w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Operand capture, per-beat accumulation
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge Vreset) begin
      if (!Vreset) begin
         r_beat   <= '0;
         r_opa    <= '0;
         r_opb    <= '0;
         r_op     <= '0;
         r_dst    <= '0;
         r_result <= '0;
         r_acc    <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (Vstart) begin
                  r_opa    <= Va;
                  r_opb    <= Vb;
                  r_op     <= Vop;
                  r_dst    <= Vdst;
                  r_result <= '0;
                  r_acc    <= '0;
                  r_beat   <= '0;
               end
            end
            ST_EXEC: begin
               for (int j = 0; j < LANES_PER_BEAT; j++) begin
                  r_result[(int'(r_beat) * LANES_PER_BEAT + j) * LANE_W +: LANE_W] <= w_lane[j];
               end
               if (r_op == c_OP_DOT) begin
                  r_acc <= w_dot_sum;
               end
               r_beat <= r_beat + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Registered outputs. The write-back triple is launched from the WB state,
   // so the strobe appears in the cycle after WB while the FSM is already
   // idle; Vwrdata/VwrAddr then hold until the next write-back.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge Vreset) begin
      if (!Vreset) begin
         r_wrdata <= '0;
         r_wraddr <= '0;
         r_wren   <= 1'b0;
         r_done   <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_wren <= (r_state == ST_WB);
         r_done <= (r_state == ST_WB);
         r_busy <= (w_state_nxt != ST_IDLE);
         if (r_state == ST_WB) begin
            r_wraddr <= r_dst;
            if (r_op == c_OP_DOT) begin
               r_wrdata <= {{(VEC_W - ACC_W){1'b0}}, r_acc};
            end else begin
               r_wrdata <= r_result;
            end
         end
      end
   end

   assign Vwrdata = r_wrdata;
   assign VwrAddr = r_wraddr;
   assign VwrEn   = r_wren;
   assign Vdone   = r_done;
   assign Vbusy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vector_lane_alu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vector_lane_alu
//  Purpose  : Self-checking bench for vector_lane_alu. A vector-level model
//             predicts each write-back from the operands accepted at Vstart;
//             directed cases pin the model with hand-computed literals.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vector_lane_alu;

   logic          clk;
   logic          Vreset;
   logic          Vstart;
   logic [1:0]    Vop;
   logic [2:0]    Vdst;
   logic [255:0]  Va;
   logic [255:0]  Vb;
   logic [255:0]  Vwrdata;
   logic [2:0]    VwrAddr;
   logic          VwrEn;
   logic          Vbusy;
   logic          Vdone;

   int n_cmp = 0;
   int n_bad = 0;

   vector_lane_alu dut (
      .clk     (clk),
      .Vreset  (Vreset),
      .Vstart  (Vstart),
      .Vop     (Vop),
      .Vdst    (Vdst),
      .Va      (Va),
      .Vb      (Vb),
      .Vwrdata (Vwrdata),
      .VwrAddr (VwrAddr),
      .VwrEn   (VwrEn),
      .Vbusy   (Vbusy),
      .Vdone   (Vdone)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Vector-level reference: whole-vector result from opcode and operands.
   function automatic logic [255:0] model_vec(input logic [1:0] op,
                                              input logic [255:0] a,
                                              input logic [255:0] b);
      logic [255:0]    r;
      longint unsigned acc;
      int unsigned     x;
      int unsigned     y;
      r   = '0;
      acc = 0;
      for (int i = 0; i < 16; i++) begin
         x = a[16*i +: 16];
         y = b[16*i +: 16];
         case (op)
            2'd0: r[16*i +: 16] = 16'(x + y);
            2'd1: r[16*i +: 16] = 16'(x - y);
            2'd2: r[16*i +: 16] = 16'(x * y);
            default: acc = acc + longint'(x) * longint'(y);
         endcase
      end
      if (op == 2'd3) r[31:0] = acc[31:0];
      return r;
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
      return v;
   endfunction

   // ------------------------------------------------------------------------
   // Model + per-cycle compare. Inputs are sampled at the rising edge; outputs
   // are compared at the following falling edge.
   // ------------------------------------------------------------------------
   int           cyc      = 0;
   int           free_at  = 0;
   int           due      = 0;
   bit           pend     = 1'b0;
   logic [255:0] exp_data = '0;
   logic [2:0]   exp_addr = '0;
   logic [255:0] last_data = '0;
   logic [2:0]   last_addr = '0;

   always begin
      bit e_en;
      bit e_busy;
      @(posedge clk);
      if (Vreset === 1'b1) begin
         cyc++;
         if (cyc >= free_at && Vstart === 1'b1) begin
            pend     = 1'b1;
            due      = cyc + 5;
            free_at  = cyc + 6;
            exp_data = model_vec(Vop, Va, Vb);
            exp_addr = Vdst;
         end
      end
      @(negedge clk);
      if (Vreset !== 1'b1) begin
         pend      = 1'b0;
         free_at   = 0;
         last_data = '0;
         last_addr = '0;
      end
      e_en   = pend && (due == cyc);
      e_busy = pend && (cyc < due);
      if (e_en) begin
         last_data = exp_data;
         last_addr = exp_addr;
         pend      = 1'b0;
      end
      chk("VwrEn",   VwrEn,   e_en);
      chk("Vdone",   Vdone,   e_en);
      chk("Vbusy",   Vbusy,   e_busy);
      chk("Vwrdata", Vwrdata, last_data);
      chk("VwrAddr", VwrAddr, last_addr);
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic scramble();
      Va   = rand256();
      Vb   = rand256();
      Vop  = 2'($urandom);
      Vdst = 3'($urandom);
   endtask

   // Issue one operation and check the write-back against literals, exactly
   // five edges after the accepting edge; operands are scrambled after capture.
   task automatic do_op(input string name, input logic [1:0] op, input logic [2:0] dst,
                        input logic [255:0] a, input logic [255:0] b,
                        input logic [255:0] exp);
      Vop = op; Vdst = dst; Va = a; Vb = b; Vstart = 1'b1;
      step();                      // accepting edge T passed
      Vstart = 1'b0;
      scramble();
      repeat (4) step();           // after edge T+4
      chk({name, "_early_wren"}, VwrEn, 1'b0);
      step();                      // after edge T+5
      chk({name, "_wren"},  VwrEn,   1'b1);
      chk({name, "_done"},  Vdone,   1'b1);
      chk({name, "_addr"},  VwrAddr, dst);
      chk({name, "_data"},  Vwrdata, exp);
      step();                      // after edge T+6
      chk({name, "_pulse_end"}, VwrEn, 1'b0);
      chk({name, "_hold"},  Vwrdata, exp);
   endtask

   initial begin
      int cnt;
      Vreset = 1'b1; Vstart = 1'b0; Vop = '0; Vdst = '0; Va = '0; Vb = '0;
      #1 Vreset = 1'b0;

      // Reset held with random inputs
      repeat (6) begin
         step();
         scramble();
         Vstart = 1'($urandom);
      end
      chk("rst_wrdata", Vwrdata, '0);
      chk("rst_wraddr", VwrAddr, '0);
      chk("rst_wren",   VwrEn,   '0);
      chk("rst_busy",   Vbusy,   '0);
      chk("rst_done",   Vdone,   '0);
      Vstart = 1'b0;
      step();
      Vreset = 1'b1;
      cnt = 0;
      repeat (20) begin
         step();
         if (VwrEn === 1'b1 || Vdone === 1'b1) cnt++;
      end
      chk("idle_no_wren", cnt, 0);

      // Directed, literal-pinned operations
      do_op("vadd", 2'd0, 3'd5, {16{16'hFFFF}}, {16{16'h0002}}, {16{16'h0001}});
      do_op("vsub", 2'd1, 3'd2,
            256'h0010_000F_000E_000D_000C_000B_000A_0009_0008_0007_0006_0005_0004_0003_0002_0001,
            {16{16'h0003}},
            256'h000D_000C_000B_000A_0009_0008_0007_0006_0005_0004_0003_0002_0001_0000_FFFF_FFFE);
      do_op("vmul", 2'd2, 3'd7, {16{16'h0100}}, {16{16'h0101}}, {16{16'h0100}});
      do_op("vdot", 2'd3, 3'd1, {16{16'hFFFF}}, {16{16'hFFFF}}, {224'h0, 32'hFFE00010});

      // Busy handling: starts at edges T+3, T+4, T+5 ignored; T+6 accepted
      scramble();
      Vstart = 1'b1;
      cnt = 0;
      for (int k = 1; k <= 6; k++) begin
         step();                   // observing state after edge T+k-1
         if (VwrEn === 1'b1) cnt++;
         scramble();
         Vstart = (k >= 3);
      end
      for (int k = 0; k < 4; k++) begin
         step();                   // after edges T+6 .. T+9
         Vstart = 1'b0;
         if (VwrEn === 1'b1) cnt++;
      end
      chk("busy_one_wren", cnt, 1);
      repeat (3) begin
         step();                   // after edges T+10 .. T+12
         if (VwrEn === 1'b1) cnt++;
      end
      chk("busy_b2b_second", cnt, 2);

      // Reset during EXEC beat 2
      scramble();
      Vstart = 1'b1;
      step();
      Vstart = 1'b0;
      step();
      step();
      Vreset = 1'b0;
      #1;
      chk("abort_busy",   Vbusy,   '0);
      chk("abort_wrdata", Vwrdata, '0);
      step();
      Vreset = 1'b1;
      cnt = 0;
      repeat (8) begin
         step();
         if (VwrEn === 1'b1 || Vdone === 1'b1) cnt++;
      end
      chk("abort_no_wren", cnt, 0);
      do_op("vadd_after_abort", 2'd0, 3'd3, {16{16'h1234}}, {16{16'h1111}}, {16{16'h2345}});

      // Randomized traffic with occasional resets
      for (int n = 0; n < 600; n++) begin
         step();
         scramble();
         Vstart = ($urandom_range(0, 2) == 0);
         Vreset = ($urandom_range(0, 80) != 0);
      end
      Vreset = 1'b1;
      Vstart = 1'b0;
      repeat (10) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
